cfg_packet_decoder: RTL and testbench
=====================================

# cfg_packet_decoder

Receives framed configuration packets from the UART receiver, validates them, and issues one register write per packet to the instrumentation blocks over a valid/ready configuration bus. It replies with a one-byte ACK or NAK on the shared UART transmitter. It sits between the UART RX/TX pair and the per-block configuration ports, and raises `cfg_busy` so tracing is paused while a write is in flight.

## Interface
Parameters:
- `NUM_BLOCKS`, default 8: number of addressable blocks. A packet with ID ≥ `NUM_BLOCKS` is rejected.
- `TIMEOUT_CYCLES`, default 50000: maximum idle gap between bytes inside a packet.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received UART byte.
- `new_rx_data`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data`  out  8  response byte.
- `new_tx_data`  out  1  one-cycle transmit strobe.
- `tx_busy`  in  1  UART transmitter busy.
- `cfg_valid`  out  1  configuration write pending.
- `cfg_ready`  in  1  target accepts the write.
- `cfg_block_id`  out  8  target block.
- `cfg_addr`  out  8  register address inside the block.
- `cfg_data`  out  16  write data.
- `cfg_busy`  out  1  high in every state except IDLE.
- `err_count`  out  8  bad or timed-out packets; saturates at 255.

## Operation
- Packet format: `0x2A`, ID, ADDR, DATA_HI, DATA_LO, CSUM. CSUM = XOR of ID through DATA_LO.
- States: IDLE → GET_ID → GET_ADDR → GET_DHI → GET_DLO → GET_CSUM → ISSUE → SEND_RESP → WAIT_RESP → IDLE.
- IDLE: a byte other than `0x2A` is ignored, with no response and no error count. `0x2A` moves the FSM to GET_ID.
- Each GET_* state captures `rx_data` on `new_rx_data` and advances by one state.
- After CSUM: if CSUM matches and ID < `NUM_BLOCKS`, go to ISSUE. Otherwise load NAK (`0x15`), increment `err_count`, and go to SEND_RESP.
- ISSUE: `cfg_valid`=1 with ID, ADDR and `{DATA_HI,DATA_LO}` stable. The write transfers in the cycle where `cfg_valid` and `cfg_ready` are both high. The FSM then loads ACK (`0x06`) and goes to SEND_RESP.
- SEND_RESP: waits for `tx_busy`=0, then drives `new_tx_data`=1 for exactly one cycle and goes to WAIT_RESP.
- WAIT_RESP: ignores `tx_busy` in the first cycle. In later cycles, goes to IDLE on the first cycle with `tx_busy`=0.
- Bytes arriving in ISSUE, SEND_RESP or WAIT_RESP are dropped silently.
- Timeout: a cycle counter runs only in GET_* states and clears on each accepted byte. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, increments `err_count`, and sends no response.
- Timeout and `new_rx_data` in the same cycle: the byte wins and the counter clears.

## Timing
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Reset asserted mid-operation aborts immediately, including a pending `cfg_valid`. No response byte is sent.
- Latency:
  - CSUM byte strobe in cycle T → `cfg_valid` high at T+1.
  - Handshake in cycle H → `new_tx_data` no earlier than H+1.
  - Bad packet: `new_tx_data` at T+1 if `tx_busy`=0.
- `cfg_*` outputs are registered and held stable while `cfg_valid`=1. `cfg_valid` never drops without a handshake, except on reset.
- `cfg_ready` may be high before `cfg_valid`. The transfer still takes exactly one cycle.
- `err_count` increments in the cycle the error is detected and saturates at 255.

## Configuration
- `CFG_CHECKSUM_EN` defined: the 6-byte format above. A CSUM mismatch produces NAK.
- `CFG_CHECKSUM_EN` undefined: 5-byte packet with no GET_CSUM state. The FSM goes from GET_DLO directly to the ID range check; only an invalid ID produces NAK.

## Structure
- Shared package `lebug_cfg_pkg`:
  - state enum;
  - constants `CFG_START_BYTE`=`0x2A`, `CFG_ACK`=`0x06`, `CFG_NAK`=`0x15`;
  - typedef `cfg_write_t` with fields block_id, addr and data.
- One sub-module, `byte_gap_timer`: a counter with clear/enable inputs and a `expired` output, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Send `2A 03 10 AB CD 75` with `cfg_ready`=1 → one write (id 3, addr `0x10`, data `0xABCD`), then a single ACK `0x06` strobe.
- Same packet with CSUM `0x00` → no `cfg_valid`, NAK `0x15`, `err_count`=1.
- ID `0x09` (with a correct CSUM) and `NUM_BLOCKS`=8 → NAK and no write. Hold `cfg_ready`=0 for 20 cycles on a valid packet → `cfg_valid` and its fields stay stable for those 20 cycles, then ACK follows the handshake.
- Send `2A 01`, then nothing for `TIMEOUT_CYCLES` → return to IDLE, `err_count`+1, no TX. Then send `41` → ignored.
- Assert `rst_n`=0 while `cfg_valid`=1 → all outputs 0 in the same cycle. After release, a valid packet is handled normally.

Source files
------------

// File: rtl/lebug_cfg_pkg.sv
// Shared types and constants for the configuration packet decoder.
package lebug_cfg_pkg;

    localparam logic [7:0] CFG_START_BYTE = 8'h2A;
    localparam logic [7:0] CFG_ACK        = 8'h06;
    localparam logic [7:0] CFG_NAK        = 8'h15;

    typedef enum logic [3:0] {
        StIdle,
        StGetId,
        StGetAddr,
        StGetDhi,
        StGetDlo,
        StGetCsum,
        StIssue,
        StSendResp,
        StWaitResp
    } cfg_state_e;

    typedef struct packed {
        logic [7:0]  block_id;
        logic [7:0]  addr;
        logic [15:0] data;
    } cfg_write_t;

    function automatic logic [7:0] cfg_csum(input cfg_write_t w);
        return w.block_id ^ w.addr ^ w.data[15:8] ^ w.data[7:0];
    endfunction

endpackage

// File: rtl/cfg_packet_decoder_if.sv
// UART byte, response and configuration-bus signals of the packet decoder.
interface cfg_packet_decoder_if;

    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_block_id;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_busy;
    logic [7:0]  err_count;

    // Decoder side.
    modport master (
        input  rx_data, new_rx_data, tx_busy, cfg_ready,
        output tx_data, new_tx_data, cfg_valid, cfg_block_id, cfg_addr, cfg_data,
        output cfg_busy, err_count
    );

    // UART and configuration-target side.
    modport slave (
        output rx_data, new_rx_data, tx_busy, cfg_ready,
        input  tx_data, new_tx_data, cfg_valid, cfg_block_id, cfg_addr, cfg_data,
        input  cfg_busy, err_count
    );

endinterface

// File: rtl/byte_gap_timer.sv
// Counts idle cycles between packet bytes; expired_o holds once the limit is reached.
module byte_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cfg_packet_decoder.sv
// Decodes framed UART config packets into one cfg-bus write each, answering ACK/NAK.
// Define CFG_CHECKSUM_EN for the 6-byte format with a trailing XOR checksum byte.
module cfg_packet_decoder
    import lebug_cfg_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic                   clk,
    input logic                   rst_n,
    cfg_packet_decoder_if.master  bus_io
);

    cfg_state_e state_q, state_d;
    cfg_write_t wr_q, wr_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] err_q, err_d;
    logic       wait_first_q;
    logic       in_get, rx_take, gap_clr, expired, id_ok, err_inc;

    assign in_get  = state_q inside {StGetId, StGetAddr, StGetDhi, StGetDlo, StGetCsum};
    assign rx_take = in_get && bus_io.new_rx_data;
    assign gap_clr = !in_get || bus_io.new_rx_data;
    assign id_ok   = 32'(wr_q.block_id) < NUM_BLOCKS;

    byte_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (gap_clr),
        .en_i      (in_get),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_q         <= '0;
            tx_q         <= '0;
            err_q        <= '0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            tx_q         <= tx_d;
            err_q        <= err_d;
            // WAIT_RESP must not trust tx_busy until the transmitter has seen the strobe.
            wait_first_q <= (state_q == StSendResp);
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        tx_d    = tx_q;
        err_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.new_rx_data && bus_io.rx_data == CFG_START_BYTE) state_d = StGetId;
            end
            StGetId: begin
                if (rx_take) begin
                    wr_d.block_id = bus_io.rx_data;
                    state_d       = StGetAddr;
                end
            end
            StGetAddr: begin
                if (rx_take) begin
                    wr_d.addr = bus_io.rx_data;
                    state_d   = StGetDhi;
                end
            end
            StGetDhi: begin
                if (rx_take) begin
                    wr_d.data[15:8] = bus_io.rx_data;
                    state_d         = StGetDlo;
                end
            end
            StGetDlo: begin
                if (rx_take) begin
                    wr_d.data[7:0] = bus_io.rx_data;
`ifdef CFG_CHECKSUM_EN
                    state_d = StGetCsum;
`else
                    if (id_ok) begin
                        state_d = StIssue;
                    end else begin
                        tx_d    = CFG_NAK;
                        err_inc = 1'b1;
                        state_d = StSendResp;
                    end
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            StGetCsum: begin
                if (rx_take) begin
                    if (id_ok && bus_io.rx_data == cfg_csum(wr_q)) begin
                        state_d = StIssue;
                    end else begin
                        tx_d    = CFG_NAK;
                        err_inc = 1'b1;
                        state_d = StSendResp;
                    end
                end
            end
`endif
            StIssue: begin
                if (bus_io.cfg_ready) begin
                    tx_d    = CFG_ACK;
                    state_d = StSendResp;
                end
            end
            StSendResp: begin
                if (!bus_io.tx_busy) state_d = StWaitResp;
            end
            StWaitResp: begin
                if (!wait_first_q && !bus_io.tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A byte in the expiry cycle still counts, so only an empty cycle can time out.
        if (in_get && !bus_io.new_rx_data && expired) begin
            state_d = StIdle;
            err_inc = 1'b1;
        end
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_comb begin
        bus_io.cfg_valid    = (state_q == StIssue);
        bus_io.cfg_block_id = wr_q.block_id;
        bus_io.cfg_addr     = wr_q.addr;
        bus_io.cfg_data     = wr_q.data;
        bus_io.tx_data      = tx_q;
        bus_io.new_tx_data  = (state_q == StSendResp) && !bus_io.tx_busy;
        bus_io.cfg_busy     = (state_q != StIdle);
        bus_io.err_count    = err_q;
    end

endmodule

// File: tb/tb_cfg_packet_decoder.sv
// Bench for cfg_packet_decoder: packet-level model with expected write/response queues.
module tb_cfg_packet_decoder;
    import lebug_cfg_pkg::*;

    localparam int unsigned NB = 8;
    localparam int unsigned TO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cfg_packet_decoder_if bus ();

    cfg_packet_decoder #(
        .NUM_BLOCKS     (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_err = 0;
    int ready_mode = 1;  // 0 random, 1 high, 2 low
    int tx_mode = 1;     // 0 random busy, 1 never busy
    int cyc = 0;
    int hs_cyc = -1;
    int n_wr = 0;
    int n_rsp = 0;
    bit hold = 1'b0;
    cfg_write_t exp_wr[$];
    logic [7:0] exp_rsp[$];
    cfg_write_t last_wr, prev_wr;
    logic [7:0] last_rsp;

    function automatic logic [7:0] pkt_csum(input logic [7:0] id, input logic [7:0] addr,
                                            input logic [15:0] data);
        return id ^ addr ^ data[15:8] ^ data[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.cfg_ready = ($urandom_range(0, 1) == 1);
            1:       bus.cfg_ready = 1'b1;
            default: bus.cfg_ready = 1'b0;
        endcase
        bus.tx_busy = (tx_mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end

    // Per-cycle comparison of bus activity against the expected queues.
    always @(negedge clk) begin
        cfg_write_t cur;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (bus.cfg_valid) begin
                cur.block_id = bus.cfg_block_id;
                cur.addr     = bus.cfg_addr;
                cur.data     = bus.cfg_data;
                if (hold) check("cfg_stable", cur, prev_wr);
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write", cur);
                end else begin
                    check("cfg_write", cur, exp_wr[0]);
                end
                if (bus.cfg_ready) begin
                    if (exp_wr.size() != 0) void'(exp_wr.pop_front());
                    n_wr++;
                    hs_cyc  = cyc;
                    last_wr = cur;
                end
                hold    = !bus.cfg_ready;
                prev_wr = cur;
            end else begin
                if (hold) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_dropped: got cfg_valid 0, expected 1 until handshake");
                end
                hold = 1'b0;
            end
            if (bus.new_tx_data) begin
                check("tx_strobe_while_busy", bus.tx_busy, 0);
                check("tx_after_handshake", cyc > hs_cyc, 1);
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got 0x%0h, expected none", bus.tx_data);
                end else begin
                    check("resp_byte", bus.tx_data, exp_rsp.pop_front());
                end
                n_rsp++;
                last_rsp = bus.tx_data;
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; strobes for exactly one cycle.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data     = b;
        bus.new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        bus.new_rx_data = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cfg_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", bus.cfg_busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_end();
        check("err_count", bus.err_count, (m_err > 255) ? 255 : m_err);
        check("writes_done", exp_wr.size(), 0);
        check("resps_done", exp_rsp.size(), 0);
    endtask

    task automatic check_outputs_zero();
        check("rst_cfg_valid", bus.cfg_valid, 0);
        check("rst_new_tx", bus.new_tx_data, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.cfg_busy, 0);
        check("rst_err", bus.err_count, 0);
        check("rst_fields", {bus.cfg_block_id, bus.cfg_addr, bus.cfg_data}, 0);
    endtask

    // trunc != 0 sends only that many bytes and expects a timeout.
    task automatic send_packet(input logic [7:0] id, input logic [7:0] addr,
                               input logic [15:0] data, input logic [7:0] csum_xor,
                               input int unsigned gap_lo, input int unsigned gap_hi,
                               input int unsigned trunc, input bit wait_done);
        logic [7:0] b[6];
        int unsigned n;
        bit good;
        cfg_write_t w;
        b[0] = CFG_START_BYTE;
        b[1] = id;
        b[2] = addr;
        b[3] = data[15:8];
        b[4] = data[7:0];
        b[5] = pkt_csum(id, addr, data) ^ csum_xor;
`ifdef CFG_CHECKSUM_EN
        n    = 6;
        good = (32'(id) < NB) && (csum_xor == 8'h00);
`else
        n    = 5;
        good = (32'(id) < NB);
`endif
        if (trunc != 0) begin
            n = trunc;
        end else if (good) begin
            w.block_id = id;
            w.addr     = addr;
            w.data     = data;
            exp_wr.push_back(w);
            exp_rsp.push_back(CFG_ACK);
        end else begin
            exp_rsp.push_back(CFG_NAK);
            m_err++;
        end
        for (int i = 0; i < int'(n); i++) begin
            if (i > 0) idle($urandom_range(gap_lo, gap_hi));
            send_byte(b[i]);
        end
        if (trunc != 0) begin
            idle(TO + 4);
            m_err++;
            check("timeout_idle", bus.cfg_busy, 0);
        end else if (wait_done) begin
            wait_idle();
        end
        if (wait_done) check_end();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int w0, r0;
        logic [7:0] s, id, addr;
        logic [15:0] data;
        logic [7:0] cx;
        int unsigned tr;
        bus.rx_data     = 8'h00;
        bus.new_rx_data = 1'b0;
        bus.tx_busy     = 1'b0;
        bus.cfg_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("model_csum", pkt_csum(8'h03, 8'h10, 16'hABCD), 32'h75);

        // Good packet with ready already high: one-cycle transfer, then ACK.
        ready_mode = 1;
        tx_mode    = 1;
        w0 = n_wr;
        r0 = n_rsp;
        send_packet(8'h03, 8'h10, 16'hABCD, 8'h00, 0, 0, 0, 0);
        #1;
        check("valid_latency", bus.cfg_valid, 1);
        @(posedge clk);
        #2;
        check("one_cycle_transfer", bus.cfg_valid, 0);
        check("ack_strobe", bus.new_tx_data, 1);
        check("ack_byte", bus.tx_data, 32'h06);
        wait_idle();
        check_end();
        check("write_count_1", n_wr - w0, 1);
        check("resp_count_1", n_rsp - r0, 1);
        check("write_fields_1", last_wr, 32'h0310ABCD);
        check("resp_1", last_rsp, 32'h06);

`ifdef CFG_CHECKSUM_EN
        // Checksum 0x00 instead of 0x75: NAK on the cycle after the last byte.
        w0 = n_wr;
        send_packet(8'h03, 8'h10, 16'hABCD, 8'h75, 0, 0, 0, 0);
        #1;
        check("nak_latency", bus.new_tx_data, 1);
        check("nak_byte", bus.tx_data, 32'h15);
        check("nak_no_valid", bus.cfg_valid, 0);
        wait_idle();
        check_end();
        check("nak_err_1", bus.err_count, 1);
        check("nak_no_write", n_wr - w0, 0);
`endif

        // Out-of-range block id with a correct checksum.
        w0 = n_wr;
        send_packet(8'h09, 8'h10, 16'hABCD, 8'h00, 0, 2, 0, 1);
        check("bad_id_no_write", n_wr - w0, 0);
        check("bad_id_nak", last_rsp, 32'h15);

        // Ready held low for 20 cycles; bytes arriving meanwhile are dropped.
        ready_mode = 2;
        tx_mode    = 0;
        w0 = n_wr;
        send_packet(8'h05, 8'h22, 16'h1234, 8'h00, 0, 3, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("held_valid", bus.cfg_valid, 1);
            check("held_fields", {bus.cfg_block_id, bus.cfg_addr, bus.cfg_data}, 32'h05221234);
        end
        @(posedge clk);
        #1;
        send_byte(8'h2A);
        send_byte(8'h03);
        check("drop_in_issue", bus.cfg_valid, 1);
        ready_mode = 1;
        wait_idle();
        check_end();
        check("held_write_count", n_wr - w0, 1);
        check("held_ack", last_rsp, 32'h06);

        // Truncated packet times out silently; a later stray byte is ignored.
        r0 = n_rsp;
        send_packet(8'h01, 8'h00, 16'h0000, 8'h00, 0, 0, 2, 1);
        check("timeout_no_tx", n_rsp - r0, 0);
        send_byte(8'h41);
        idle(5);
        check("stray_ignored", bus.cfg_busy, 0);
        check_end();

        // Every gap exactly at the timeout limit: each byte wins over expiry.
        send_packet(8'h02, 8'h33, 16'h5A5A, 8'h00, TO, TO, 0, 1);
        check("gap_limit_ack", last_rsp, 32'h06);

        // Reset while a write is pending.
        ready_mode = 2;
        tx_mode    = 1;
        send_packet(8'h04, 8'h44, 16'hBEEF, 8'h00, 0, 0, 0, 0);
        #1;
        check("pre_reset_valid", bus.cfg_valid, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero();
        exp_wr.delete();
        exp_rsp.delete();
        m_err = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        w0 = n_wr;
        send_packet(8'h06, 8'h01, 16'h0F0F, 8'h00, 0, 1, 0, 1);
        check("post_reset_write", n_wr - w0, 1);

        // Randomized traffic.
        tx_mode = 0;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                s = 8'($urandom());
                if (s == CFG_START_BYTE) s = 8'h2B;
                send_byte(s);
                idle(2);
                check("rand_stray", bus.cfg_busy, 0);
            end
            id   = 8'($urandom_range(0, 11));
            addr = 8'($urandom());
            data = 16'($urandom());
            cx   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            tr   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
            send_packet(id, addr, data, cx, 0, 3, tr, 1);
        end

        // Drive the error counter into saturation.
        for (int k = 0; k < 260; k++) begin
            send_packet(8'($urandom_range(NB, 255)), 8'h00, 16'($urandom()), 8'h00, 0, 1, 0, 1);
        end
        check("err_saturated", bus.err_count, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
